// File: rtl/duck_motion_ctrl.sv
// Multi-duck movement controller: steps each duck once per game tick and
// erases/redraws moved ducks through a req/done handshake with the VGA drawer.
// rand_dir carries the random direction bits (rand is a reserved word).
module duck_motion_ctrl #(
    parameter int NUM_DUCKS = 2,
    parameter int X_W       = 8,
    parameter int Y_W       = 7,
    parameter int X_MAX     = 152,
    parameter int Y_MAX     = 112,
    parameter int STEP      = 4,
    localparam int IDW      = (NUM_DUCKS > 1) ? $clog2(NUM_DUCKS) : 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   tick,
    input  logic [1:0]             rand_dir,
    input  logic [NUM_DUCKS-1:0]   shot,
    input  logic                   escape,
    input  logic                   leave,
    input  logic                   draw_done,
    output logic                   draw_req,
    output logic                   draw_erase,
    output logic [IDW-1:0]         draw_id,
    output logic [X_W-1:0]         draw_x,
    output logic [Y_W-1:0]         draw_y,
    output logic [2*NUM_DUCKS-1:0] duck_mode,
    output logic                   all_gone,
    output logic                   overrun
);

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_SELECT, S_ERASE, S_UPDATE, S_DRAW, S_NEXT
    } state_t;

    typedef enum logic [1:0] {
        M_FREE    = 2'b00,
        M_FALLING = 2'b01,
        M_FLYING  = 2'b10,
        M_GONE    = 2'b11
    } mode_t;

    state_t               state, state_nxt;
    logic [IDW-1:0]       idx, idx_nxt;
    logic                 init_pass, init_pass_nxt;
    logic [X_W-1:0]       x_pos [NUM_DUCKS];
    logic [X_W-1:0]       x_nxt [NUM_DUCKS];
    logic [Y_W-1:0]       y_pos [NUM_DUCKS];
    logic [Y_W-1:0]       y_nxt [NUM_DUCKS];
    mode_t                mode [NUM_DUCKS];
    mode_t                mode_nxt [NUM_DUCKS];
    logic [NUM_DUCKS-1:0] shot_pend, shot_pend_nxt, shot_eff;
    logic                 esc_pend, esc_pend_nxt, esc_eff;
    logic                 leave_pend, leave_pend_nxt, leave_eff;
    logic                 tick_q, tick_edge;
    logic                 all_gone_c;
    int                   cur_x, cur_y, new_x, new_y;

    function automatic logic [X_W-1:0] spawn_x(input int i);
        return X_W'(((i + 1) * X_MAX) / (NUM_DUCKS + 1));
    endfunction

    assign tick_edge = tick & ~tick_q;
    // Events arriving in the same cycle as the tick edge still take effect
    assign shot_eff  = shot_pend | shot;
    assign esc_eff   = esc_pend | escape;
    assign leave_eff = leave_pend | leave;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_INIT;
            idx        <= '0;
            init_pass  <= 1'b0;
            shot_pend  <= '0;
            esc_pend   <= 1'b0;
            leave_pend <= 1'b0;
            tick_q     <= 1'b0;
            overrun    <= 1'b0;
            all_gone   <= 1'b0;
            for (int i = 0; i < NUM_DUCKS; i++) begin
                x_pos[i] <= spawn_x(i);
                y_pos[i] <= Y_W'(Y_MAX);
                mode[i]  <= M_FREE;
            end
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            init_pass  <= init_pass_nxt;
            shot_pend  <= shot_pend_nxt;
            esc_pend   <= esc_pend_nxt;
            leave_pend <= leave_pend_nxt;
            tick_q     <= tick;
            overrun    <= tick_edge && (state != S_IDLE);
            all_gone   <= all_gone_c;
            x_pos      <= x_nxt;
            y_pos      <= y_nxt;
            mode       <= mode_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        idx_nxt        = idx;
        init_pass_nxt  = init_pass;
        x_nxt          = x_pos;
        y_nxt          = y_pos;
        mode_nxt       = mode;
        shot_pend_nxt  = shot_eff;
        esc_pend_nxt   = esc_eff;
        leave_pend_nxt = leave_eff;
        cur_x          = int'(x_pos[idx]);
        cur_y          = int'(y_pos[idx]);
        new_x          = cur_x;
        new_y          = cur_y;
        draw_req       = 1'b0;
        draw_erase     = 1'b0;
        draw_id        = '0;
        draw_x         = '0;
        draw_y         = '0;

        case (state)
            S_INIT: begin
                idx_nxt       = '0;
                init_pass_nxt = 1'b1;
                state_nxt     = S_DRAW;
            end
            S_IDLE: begin
                if (tick_edge) begin
                    idx_nxt = '0;
                    if (leave_eff) begin
                        for (int i = 0; i < NUM_DUCKS; i++) begin
                            x_nxt[i]    = spawn_x(i);
                            y_nxt[i]    = Y_W'(Y_MAX);
                            mode_nxt[i] = M_FREE;
                        end
                        shot_pend_nxt  = '0;
                        esc_pend_nxt   = 1'b0;
                        leave_pend_nxt = 1'b0;
                        state_nxt      = S_INIT;
                    end else begin
                        for (int i = 0; i < NUM_DUCKS; i++) begin
                            if (mode[i] == M_FREE) begin
                                if (shot_eff[i])
                                    mode_nxt[i] = M_FALLING;
                                else if (esc_eff)
                                    mode_nxt[i] = M_FLYING;
                            end
                        end
                        shot_pend_nxt = '0;
                        esc_pend_nxt  = 1'b0;
                        state_nxt     = S_SELECT;
                    end
                end
            end
            S_SELECT: begin
                state_nxt = (mode[idx] == M_GONE) ? S_NEXT : S_ERASE;
            end
            S_ERASE: begin
                draw_req   = 1'b1;
                draw_erase = 1'b1;
                draw_id    = idx;
                draw_x     = x_pos[idx];
                draw_y     = y_pos[idx];
                if (draw_done)
                    state_nxt = S_UPDATE;
            end
            S_UPDATE: begin
                // Arithmetic is done in int so clamping never sees a wrapped value
                case (mode[idx])
                    M_FREE: begin
                        new_x = rand_dir[0] ? cur_x + STEP : cur_x - STEP;
                        new_y = rand_dir[1] ? cur_y + STEP : cur_y - STEP;
                        if (new_x < 0)     new_x = 0;
                        if (new_x > X_MAX) new_x = X_MAX;
                        if (new_y < 0)     new_y = 0;
                        if (new_y > Y_MAX) new_y = Y_MAX;
                    end
                    M_FALLING: begin
                        new_y = cur_y + STEP;
                        if (new_y >= Y_MAX) begin
                            new_y         = Y_MAX;
                            mode_nxt[idx] = M_GONE;
                        end
                    end
                    M_FLYING: begin
                        if (cur_y < STEP)
                            mode_nxt[idx] = M_GONE;
                        else
                            new_y = cur_y - STEP;
                    end
                    default: mode_nxt[idx] = M_GONE;
                endcase
                x_nxt[idx] = X_W'(new_x);
                y_nxt[idx] = Y_W'(new_y);
                state_nxt  = (mode_nxt[idx] == M_GONE) ? S_NEXT : S_DRAW;
            end
            S_DRAW: begin
                draw_req = 1'b1;
                draw_id  = idx;
                draw_x   = x_pos[idx];
                draw_y   = y_pos[idx];
                if (draw_done)
                    state_nxt = S_NEXT;
            end
            S_NEXT: begin
                if (idx == IDW'(NUM_DUCKS - 1)) begin
                    init_pass_nxt = 1'b0;
                    state_nxt     = S_IDLE;
                end else begin
                    idx_nxt   = idx + 1'b1;
                    state_nxt = init_pass ? S_DRAW : S_SELECT;
                end
            end
            default: state_nxt = S_INIT;
        endcase
    end

    always_comb begin
        all_gone_c = 1'b1;
        for (int i = 0; i < NUM_DUCKS; i++)
            if (mode[i] != M_GONE)
                all_gone_c = 1'b0;
    end

    for (genvar g = 0; g < NUM_DUCKS; g++) begin : g_mode
        assign duck_mode[2*g +: 2] = mode[g];
    end

endmodule

// File: tb/tb_duck_motion_ctrl.sv
// Scoreboard bench for duck_motion_ctrl: a reference model queues the expected
// drawer requests for each tick and a monitor checks every accepted request.
module tb_duck_motion_ctrl;

    localparam int NUM   = 2;
    localparam int X_MAX = 152;
    localparam int Y_MAX = 112;
    localparam int STEP  = 4;

    logic           clk, reset_n, tick, escape, leave, draw_done;
    logic [1:0]     rand_dir;
    logic [NUM-1:0] shot;
    logic           draw_req, draw_erase, all_gone, overrun;
    logic [0:0]     draw_id;
    logic [7:0]     draw_x;
    logic [6:0]     draw_y;
    logic [3:0]     duck_mode;

    duck_motion_ctrl dut (
        .clk(clk), .reset_n(reset_n), .tick(tick), .rand_dir(rand_dir),
        .shot(shot), .escape(escape), .leave(leave), .draw_done(draw_done),
        .draw_req(draw_req), .draw_erase(draw_erase), .draw_id(draw_id),
        .draw_x(draw_x), .draw_y(draw_y), .duck_mode(duck_mode),
        .all_gone(all_gone), .overrun(overrun)
    );

    typedef struct {
        logic erase;
        int   id;
        int   x;
        int   y;
    } req_t;

    req_t       exp_q[$];
    int         checks = 0;
    int         fails  = 0;
    int         drawer_mode = 0;
    int         mx [NUM];
    int         my [NUM];
    logic [1:0] mm [NUM];
    logic [NUM-1:0] m_shot;
    logic       m_esc, m_leave;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Drawer: 0 = done tied high, 1 = random latency pulses, 2 = held low
    initial begin
        int lat;
        lat = 0;
        draw_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (drawer_mode == 0)
                draw_done = 1'b1;
            else if (drawer_mode == 2)
                draw_done = 1'b0;
            else if (draw_done)
                draw_done = 1'b0;
            else if (draw_req) begin
                if (lat == 0) begin
                    draw_done = 1'b1;
                    lat = $urandom_range(0, 3);
                end else
                    lat--;
            end
        end
    end

    // Every accepted request is popped and compared against the model
    initial begin
        req_t e;
        forever begin
            @(negedge clk);
            if (reset_n === 1'b1 && draw_req === 1'b1 && draw_done === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("[TB] FAIL unexpected_req: got erase=%0b id=%0d x=%0d y=%0d, required none",
                             draw_erase, draw_id, draw_x, draw_y);
                end else begin
                    e = exp_q.pop_front();
                    if (draw_erase !== e.erase || draw_id !== 1'(e.id) ||
                        draw_x !== 8'(e.x) || draw_y !== 7'(e.y)) begin
                        fails++;
                        $display("[TB] FAIL draw_req: got erase=%0b id=%0d x=%0d y=%0d, required erase=%0b id=%0d x=%0d y=%0d",
                                 draw_erase, draw_id, draw_x, draw_y, e.erase, e.id, e.x, e.y);
                    end
                end
            end
        end
    end

    function automatic int spawn_x(input int i);
        return ((i + 1) * X_MAX) / (NUM + 1);
    endfunction

    function automatic logic [3:0] model_modes();
        logic [3:0] m;
        for (int i = 0; i < NUM; i++)
            m[2*i +: 2] = mm[i];
        return m;
    endfunction

    function automatic logic model_all_gone();
        logic g;
        g = 1'b1;
        for (int i = 0; i < NUM; i++)
            if (mm[i] != 2'b11) g = 1'b0;
        return g;
    endfunction

    task automatic push_req(input logic e, input int id, input int x, input int y);
        req_t r;
        r.erase = e; r.id = id; r.x = x; r.y = y;
        exp_q.push_back(r);
    endtask

    task automatic push_spawn();
        for (int i = 0; i < NUM; i++) begin
            mx[i] = spawn_x(i);
            my[i] = Y_MAX;
            mm[i] = 2'b00;
            push_req(1'b0, i, mx[i], my[i]);
        end
    endtask

    task automatic model_step(input logic [1:0] rnd);
        if (m_leave) begin
            m_leave = 1'b0;
            m_shot  = '0;
            m_esc   = 1'b0;
            push_spawn();
        end else begin
            for (int i = 0; i < NUM; i++)
                if (mm[i] == 2'b00) begin
                    if (m_shot[i])  mm[i] = 2'b01;
                    else if (m_esc) mm[i] = 2'b10;
                end
            m_shot = '0;
            m_esc  = 1'b0;
            for (int i = 0; i < NUM; i++) begin
                if (mm[i] != 2'b11) begin
                    push_req(1'b1, i, mx[i], my[i]);
                    case (mm[i])
                        2'b00: begin
                            mx[i] = rnd[0] ? ((mx[i] + STEP > X_MAX) ? X_MAX : mx[i] + STEP)
                                           : ((mx[i] < STEP) ? 0 : mx[i] - STEP);
                            my[i] = rnd[1] ? ((my[i] + STEP > Y_MAX) ? Y_MAX : my[i] + STEP)
                                           : ((my[i] < STEP) ? 0 : my[i] - STEP);
                        end
                        2'b01: begin
                            if (my[i] + STEP >= Y_MAX) mm[i] = 2'b11;
                            else my[i] = my[i] + STEP;
                        end
                        default: begin
                            if (my[i] < STEP) mm[i] = 2'b11;
                            else my[i] = my[i] - STEP;
                        end
                    endcase
                    if (mm[i] != 2'b11)
                        push_req(1'b0, i, mx[i], my[i]);
                end
            end
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("[TB] FAIL drain: %0d requests still outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic do_tick(input logic [1:0] rnd);
        rand_dir = rnd;
        model_step(rnd);
        tick = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tick = 1'b0;
        wait_idle();
        checks++;
        if (duck_mode !== model_modes()) begin
            fails++;
            $display("[TB] FAIL tick_modes: got %b, required %b", duck_mode, model_modes());
        end
        checks++;
        if (all_gone !== model_all_gone()) begin
            fails++;
            $display("[TB] FAIL tick_all_gone: got %b, required %b", all_gone, model_all_gone());
        end
    endtask

    task automatic pulse_events(input logic [NUM-1:0] s, input logic esc, input logic lv);
        shot = s; escape = esc; leave = lv;
        @(posedge clk);
        #1;
        shot = '0; escape = 1'b0; leave = 1'b0;
        m_shot  = m_shot | s;
        m_esc   = m_esc | esc;
        m_leave = m_leave | lv;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; tick = 1'b0; rand_dir = 2'b00; shot = '0;
        escape = 1'b0; leave = 1'b0; drawer_mode = 0;
        m_shot = '0; m_esc = 1'b0; m_leave = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (draw_req !== 1'b0 || draw_erase !== 1'b0 || draw_id !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_req: got req=%b erase=%b id=%b, required 0 0 0", draw_req, draw_erase, draw_id);
        end
        checks++;
        if (draw_x !== 8'd0 || draw_y !== 7'd0) begin
            fails++;
            $display("[TB] FAIL reset_xy: got x=%0d y=%0d, required 0 0", draw_x, draw_y);
        end
        checks++;
        if (duck_mode !== 4'b0000 || all_gone !== 1'b0 || overrun !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_status: got modes=%b all_gone=%b overrun=%b, required 0000 0 0",
                     duck_mode, all_gone, overrun);
        end
        push_spawn();
        reset_n = 1'b1;
        wait_idle();
    endtask

    task automatic test_clamp_corner();
        for (int k = 0; k < 14; k++) begin
            if (k == 7) drawer_mode = 1;
            do_tick(2'b10);
        end
        drawer_mode = 0;
    endtask

    task automatic test_shot_escape();
        for (int k = 0; k < 3; k++) do_tick(2'b00);
        pulse_events(2'b01, 1'b1, 1'b0);
        do_tick(2'b00);
        checks++;
        if (duck_mode !== 4'b1001) begin
            fails++;
            $display("[TB] FAIL shot_escape_modes: got %b, required 1001", duck_mode);
        end
        for (int k = 0; k < 40 && !model_all_gone(); k++) begin
            if (k == 1) pulse_events(2'b11, 1'b0, 1'b0);
            do_tick(2'($urandom_range(0, 3)));
        end
        checks++;
        if (all_gone !== 1'b1 || duck_mode !== 4'b1111) begin
            fails++;
            $display("[TB] FAIL all_gone: got all_gone=%b modes=%b, required 1 1111", all_gone, duck_mode);
        end
        do_tick(2'b11);
    endtask

    task automatic test_leave();
        pulse_events(2'b11, 1'b0, 1'b0);
        pulse_events(2'b00, 1'b0, 1'b1);
        do_tick(2'b01);
        checks++;
        if (duck_mode !== 4'b0000 || all_gone !== 1'b0) begin
            fails++;
            $display("[TB] FAIL leave_respawn: got modes=%b all_gone=%b, required 0000 0", duck_mode, all_gone);
        end
        do_tick(2'b11);
        checks++;
        if (duck_mode !== 4'b0000) begin
            fails++;
            $display("[TB] FAIL leave_clears_shot: got modes=%b, required 0000", duck_mode);
        end
    endtask

    task automatic test_shot_fall();
        for (int k = 0; k < 3; k++) do_tick(2'b00);
        pulse_events(2'b10, 1'b0, 1'b0);
        do_tick(2'b00);
        checks++;
        if (duck_mode[3:2] !== 2'b01) begin
            fails++;
            $display("[TB] FAIL shot_falling: got %b, required 01", duck_mode[3:2]);
        end
        for (int k = 0; k < 10 && mm[1] != 2'b11; k++)
            do_tick(2'b00);
        checks++;
        if (duck_mode[3:2] !== 2'b11 || all_gone !== 1'b0) begin
            fails++;
            $display("[TB] FAIL fall_gone: got mode1=%b all_gone=%b, required 11 0", duck_mode[3:2], all_gone);
        end
    endtask

    task automatic test_overrun();
        int n, highs;
        drawer_mode = 2;
        rand_dir = 2'b01;
        model_step(2'b01);
        tick = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (draw_req !== 1'b1 && n < 20);
        checks++;
        if (draw_req !== 1'b1 || draw_erase !== 1'b1) begin
            fails++;
            $display("[TB] FAIL overrun_erase_wait: got req=%b erase=%b, required 1 1", draw_req, draw_erase);
        end
        @(posedge clk); #1; tick = 1'b0;
        @(posedge clk); #1; tick = 1'b1;
        highs = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (overrun === 1'b1) highs++;
        end
        checks++;
        if (highs != 1) begin
            fails++;
            $display("[TB] FAIL overrun_pulse: got %0d cycles high, required 1", highs);
        end
        @(posedge clk); #1;
        tick = 1'b0;
        drawer_mode = 0;
        wait_idle();
        checks++;
        if (duck_mode !== model_modes()) begin
            fails++;
            $display("[TB] FAIL overrun_modes: got %b, required %b", duck_mode, model_modes());
        end
    endtask

    task automatic test_back_to_back();
        drawer_mode = 1;
        for (int k = 0; k < 6; k++) begin
            if (k == 3) pulse_events(2'b00, 1'b1, 1'b0);
            do_tick(2'($urandom_range(0, 3)));
        end
        drawer_mode = 0;
    endtask

    initial begin
        test_reset();
        test_clamp_corner();
        test_shot_escape();
        test_leave();
        test_shot_fall();
        test_overrun();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
